// File: rtl/uart_rx_fifo_pkg.sv
// Controller-visible constants shared between the RX byte buffer and the UART controller.
// Status bit positions and register offsets for the RX side of the memory map.
package uart_rx_fifo_pkg;

    localparam int unsigned RX_STAT_VALID   = 0;
    localparam int unsigned RX_STAT_BREAK   = 2;
    localparam int unsigned RX_STAT_OVERRUN = 3;
    localparam int unsigned RX_STAT_IRQ     = 4;

    localparam logic [7:0] RXDATA_OFFSET = 8'h08;
    localparam logic [7:0] RXCTRL_OFFSET = 8'h0C;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between uart_rx and the UART controller, with sticky
// overrun/break status and a level-threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned THRESHOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_break,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr_status,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     brk,
    output logic                     irq_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESHOLD);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      next_count;
    logic             brk_q;
    logic             pop_ok;
    logic             push_ok;
    logic             overrun_set;
    logic             brk_set;

    assign out_valid   = (count != '0);
    assign full        = (count == DEPTH_C);
    assign level       = count;
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    // A pop in the same cycle frees a slot, so a byte arriving while full is still accepted.
    assign pop_ok      = rd_en && out_valid;
    assign push_ok     = in_valid && (!full || pop_ok);
    assign overrun_set = in_valid && full && !pop_ok;
    assign brk_set     = in_break && !brk_q;

    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (push_ok && !pop_ok) begin
            next_count = count + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            next_count = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            irq_level <= 1'b0;
            overrun   <= 1'b0;
            brk       <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            count     <= next_count;
            irq_level <= (next_count >= THRESH_C);
            brk_q     <= in_break;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            // Set events take priority over a clear in the same cycle.
            if (overrun_set)     overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (brk_set)         brk <= 1'b1;
            else if (clr_status) brk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_break;
    logic       rd_en;
    logic       flush;
    logic       clr_status;
    logic [7:0] out_data;
    logic       out_valid;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       brk;
    logic       irq_level;

    int passed = 0;
    int total  = 0;

    byte unsigned q[$];
    bit m_ovr, m_brk, m_brk_prev;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8), .THRESHOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_break(in_break), .rd_en(rd_en), .flush(flush), .clr_status(clr_status),
        .out_data(out_data), .out_valid(out_valid), .full(full), .level(level),
        .overrun(overrun), .brk(brk), .irq_level(irq_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       r;
        bit       f;
        int       lvl;
        bit       ov;
        int       od;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit [7:0] d, bit r, bit f, int lvl, bit ov, int od);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.f = f; t.lvl = lvl; t.ov = ov; t.od = od;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(string tag, int lvl, bit v, int d, bit f, bit o, bit b, bit irq);
        chk({tag, " level"},     int'(level),     lvl);
        chk({tag, " out_valid"}, int'(out_valid), int'(v));
        chk({tag, " out_data"},  int'(out_data),  d);
        chk({tag, " full"},      int'(full),      int'(f));
        chk({tag, " overrun"},   int'(overrun),   int'(o));
        chk({tag, " brk"},       int'(brk),       int'(b));
        chk({tag, " irq_level"}, int'(irq_level), int'(irq));
    endtask

    // Reference behaviour: a byte queue plus sticky flags, advanced once per clock edge.
    function automatic void model_step(bit v, byte unsigned d, bit b, bit r, bit f, bit c);
        bit pop, was_full, ovr_set, brk_set;
        pop      = r && (q.size() > 0);
        was_full = (q.size() == 16);
        ovr_set  = v && was_full && !pop;
        brk_set  = b && !m_brk_prev;
        m_brk_prev = b;
        if (f) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (v && (!was_full || pop)) q.push_back(d);
        end
        if (ovr_set) m_ovr = 1'b1; else if (c) m_ovr = 1'b0;
        if (brk_set) m_brk = 1'b1; else if (c) m_brk = 1'b0;
    endfunction

    task automatic model_chk(string tag);
        int sz;
        sz = q.size();
        chk_all(tag, sz, sz != 0, (sz != 0) ? int'(q[0]) : 0, sz == 16, m_ovr, m_brk, sz >= 8);
    endtask

    task automatic step(bit v, bit [7:0] d, bit b, bit r, bit f, bit c);
        in_valid = v; in_data = d; in_break = b; rd_en = r; flush = f; clr_status = c;
        @(posedge clk);
        model_step(v, d, b, r, f, c);
        #1;
        in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_status = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; in_break = 1'b0; rd_en = 1'b0;
        flush = 1'b0; clr_status = 1'b0;
        rst_n = 1'b0;
        q.delete(); m_ovr = 1'b0; m_brk = 1'b0; m_brk_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int p;
        bit b_lvl;

        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_break = 1'b0; rd_en = 1'b0;
        flush = 1'b0; clr_status = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Directed table: basic FWFT order, empty push+pop, flush discarding an arriving byte.
        tbl.push_back(mk(1, 8'h41, 0, 0, 1, 1, 8'h41));
        tbl.push_back(mk(1, 8'h42, 0, 0, 2, 1, 8'h41));
        tbl.push_back(mk(1, 8'h43, 0, 0, 3, 1, 8'h41));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'h42));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h43));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h77, 1, 0, 1, 1, 8'h77));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, 8'(i), 0, 0, i, 1, 8'h01));
        tbl.push_back(mk(1, 8'h99, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h12, 0, 0, 1, 1, 8'h12));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00));
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, 1'b0, tbl[i].r, tbl[i].f, 1'b0);
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].ov, tbl[i].od, 0, 0, 0, 0);
        end

        // Asynchronous reset with bytes buffered.
        for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0, 0);
        rst_n = 1'b0;
        #1 chk_all("midreset", 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Fill to DEPTH, crossing the threshold, then overrun.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0, 0);
            chk_all($sformatf("fill%0d", i), i + 1, 1, 0, i == 15, 0, 0, (i + 1) >= 8);
        end
        step(1, 8'hAA, 0, 0, 0, 0);
        chk_all("overrun", 16, 1, 0, 1, 1, 0, 1);
        step(1, 8'hBB, 0, 0, 0, 1);
        chk_all("ovr_setwins", 16, 1, 0, 1, 1, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);
        chk_all("ovr_clr", 16, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), int'(out_data), i);
            step(0, 8'h00, 0, 1, 0, 0);
        end
        chk_all("drained", 0, 0, 0, 0, 0, 0, 0);

        // Full with simultaneous push and pop: byte accepted, no overrun.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
        step(1, 8'h55, 0, 1, 0, 0);
        chk_all("full_pushpop", 16, 1, 8'h01, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain55_%0d", i), int'(out_data), (i == 15) ? 8'h55 : i + 1);
            step(0, 8'h00, 0, 1, 0, 0);
        end
        chk("drain55 empty", int'(out_valid), 0);

        // Break: held level sets once, clear on fall, set wins over clear.
        do_reset();
        for (int i = 0; i < 100; i++) step(0, 8'h00, 1, 0, 0, 0);
        chk("brk held", int'(brk), 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("brk no retrigger", int'(brk), 0);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("brk clr on fall", int'(brk), 0);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("brk set wins", int'(brk), 1);
        step(0, 8'h00, 1, 0, 1, 0);
        chk("brk survives flush", int'(brk), 1);

        // Randomized traffic against the reference model.
        do_reset();
        b_lvl = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            p = ((n / 150) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 99) < 5) b_lvl = ~b_lvl;
            step($urandom_range(0, 99) < p, 8'($urandom), b_lvl,
                 $urandom_range(0, 99) < (100 - p),
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 4);
            model_chk($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
